// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - shared constants and state encoding for the ALU command sequencer
package alu_cmd_pkg;

    localparam int FUN_WIDTH = 4;

    localparam logic [7:0] OPD_CMD_DEF  = 8'hCC;
    localparam logic [7:0] NOPD_CMD_DEF = 8'hDD;
    localparam logic [7:0] ERR_BYTE     = 8'hEE;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_GET_A    = 4'd1;
    localparam state_t ST_GET_B    = 4'd2;
    localparam state_t ST_GET_FUN  = 4'd3;
    localparam state_t ST_EXEC     = 4'd4;
    localparam state_t ST_WAIT_RES = 4'd5;
    localparam state_t ST_SEND_LO  = 4'd6;
    localparam state_t ST_SEND_HI  = 4'd7;
    localparam state_t ST_SEND_ERR = 4'd8;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART byte-frame parser driving the ALU and returning its 16-bit result
// Optional error-byte reply for unknown opcodes: define ALU_CMD_ERR_RESP_EN.
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    OUT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] OPD_CMD    = DATA_WIDTH'(OPD_CMD_DEF),
    parameter logic [DATA_WIDTH-1:0] NOPD_CMD   = DATA_WIDTH'(NOPD_CMD_DEF)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VALID,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_VALID,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY
);

    state_t                state;
    logic [DATA_WIDTH-1:0] result_hi;

    assign ALU_EN = (state == ST_EXEC);
    assign BUSY   = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_FUN   <= '0;
            result_hi <= '0;
            TX_DATA   <= '0;
            TX_VALID  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (RX_VALID) begin
                        if (RX_DATA == OPD_CMD) begin
                            state <= ST_GET_A;
                        end else if (RX_DATA == NOPD_CMD) begin
                            state <= ST_GET_FUN;
                        end
`ifdef ALU_CMD_ERR_RESP_EN
                        else begin
                            state    <= ST_SEND_ERR;
                            TX_DATA  <= DATA_WIDTH'(ERR_BYTE);
                            TX_VALID <= 1'b1;
                        end
`endif
                    end
                end
                ST_GET_A: begin
                    if (RX_VALID) begin
                        ALU_A <= RX_DATA;
                        state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (RX_VALID) begin
                        ALU_B <= RX_DATA;
                        state <= ST_GET_FUN;
                    end
                end
                ST_GET_FUN: begin
                    if (RX_VALID) begin
                        ALU_FUN <= RX_DATA[FUN_WIDTH-1:0];
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    // Low byte goes straight to the TX register; only the high byte needs holding.
                    if (ALU_VALID) begin
                        result_hi <= ALU_OUT[OUT_WIDTH-1:DATA_WIDTH];
                        TX_DATA   <= ALU_OUT[DATA_WIDTH-1:0];
                        TX_VALID  <= 1'b1;
                        state     <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    if (TX_READY) begin
                        TX_DATA <= result_hi;
                        state   <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    if (TX_READY) begin
                        TX_VALID <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
`ifdef ALU_CMD_ERR_RESP_EN
                ST_SEND_ERR: begin
                    if (TX_READY) begin
                        TX_VALID <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    TX_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl with a registered ALU model
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_VALID;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;

    logic [15:0] next_res;
    int          xfers = 0;
    int          pass_cnt = 0;
    int          total = 0;

    alu_cmd_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .ALU_FUN   (ALU_FUN),
        .ALU_EN    (ALU_EN),
        .ALU_OUT   (ALU_OUT),
        .ALU_VALID (ALU_VALID),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // ALU stand-in: output registered one cycle after ALU_EN
    always @(posedge CLK) begin
        if (RST) begin
            ALU_VALID <= 1'b0;
            ALU_OUT   <= 16'h0000;
        end else begin
            ALU_VALID <= ALU_EN;
            if (ALU_EN) ALU_OUT <= next_res;
        end
        if (TX_VALID && TX_READY) xfers <= xfers + 1;
    end

    typedef struct {
        string       name;
        logic [31:0] rx;
        int          n;
        logic [15:0] res;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [3:0]  ef;
        logic [7:0]  elo;
        logic [7:0]  ehi;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic recv(input string nm, input logic [7:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (TX_VALID && TX_READY) begin
                chk(nm, TX_DATA, exp);
                got = 1'b1;
            end
            tick();
        end
        if (!got) begin
            total++;
            $display("FAIL %s: got no TX byte expected %0h", nm, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int x0;
        next_res = v.res;
        x0 = xfers;
        for (int i = 0; i < v.n; i++) send_rx(v.rx[31-8*i -: 8]);
        chk({v.name, " en_hi"}, ALU_EN, 1);
        chk({v.name, " a"}, ALU_A, v.ea);
        chk({v.name, " b"}, ALU_B, v.eb);
        chk({v.name, " fun"}, ALU_FUN, v.ef);
        tick();
        chk({v.name, " en_lo"}, ALU_EN, 0);
        chk({v.name, " busy_wait"}, BUSY, 1);
        tick();
        chk({v.name, " tx_latency"}, TX_VALID, 1);
        recv({v.name, " lo"}, v.elo);
        recv({v.name, " hi"}, v.ehi);
        chk({v.name, " tx_drop"}, TX_VALID, 0);
        chk({v.name, " idle"}, BUSY, 0);
        chk({v.name, " xfers"}, xfers - x0, 2);
    endtask

    vec_t vecs[4];
    vec_t v;
    int   x0;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"cc_add",  32'hCC050300, 4, 16'h0008, 8'h05, 8'h03, 4'h0, 8'h08, 8'h00};
        vecs[1] = '{"dd_reuse", 32'hDD020000, 2, 16'h000F, 8'h05, 8'h03, 4'h2, 8'h0F, 8'h00};
        vecs[2] = '{"cc_funhi", 32'hCCA55AF1, 4, 16'h1234, 8'hA5, 8'h5A, 4'h1, 8'h34, 8'h12};
        vecs[3] = '{"dd_f15",  32'hDD0F0000, 2, 16'h0000, 8'hA5, 8'h5A, 4'hF, 8'h00, 8'h00};

        RST = 1'b1; RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b1; next_res = 16'h0000;
        tick(); tick();
        RST = 1'b0;
        chk("rst busy", BUSY, 0);
        chk("rst tx_valid", TX_VALID, 0);
        chk("rst tx_data", TX_DATA, 0);
        chk("rst alu_en", ALU_EN, 0);
        chk("rst a_b_fun", {ALU_A, ALU_B, ALU_FUN}, 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Back-pressure in SEND_LO: low byte must hold
        TX_READY = 1'b0;
        next_res = 16'hFE01;
        x0 = xfers;
        send_rx(8'hCC); send_rx(8'hFF); send_rx(8'hFF); send_rx(8'h02);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall tx_valid", TX_VALID, 1);
            chk("stall tx_data", TX_DATA, 8'h01);
            tick();
        end
        TX_READY = 1'b1;
        recv("stall lo", 8'h01);
        recv("stall hi", 8'hFE);
        chk("stall xfers", xfers - x0, 2);
        chk("stall idle", BUSY, 0);

        // Unrecognised opcode
        x0 = xfers;
        send_rx(8'h55);
`ifdef ALU_CMD_ERR_RESP_EN
        chk("err busy", BUSY, 1);
        recv("err byte", 8'hEE);
        chk("err tx_drop", TX_VALID, 0);
        chk("err xfers", xfers - x0, 1);
        v = '{"after_err", 32'hCC0102_03, 4, 16'h0003, 8'h01, 8'h02, 4'h3, 8'h03, 8'h00};
        run_frame(v);
`else
        for (int i = 0; i < 4; i++) begin
            chk("bad busy", BUSY, 0);
            chk("bad tx_valid", TX_VALID, 0);
            tick();
        end
        chk("bad xfers", xfers - x0, 0);
`endif

        // Bytes arriving while busy are dropped
        next_res = 16'h3344;
        send_rx(8'hCC); send_rx(8'h11); send_rx(8'h22); send_rx(8'h03);
        TX_READY = 1'b0;
        send_rx(8'hAA); send_rx(8'hBB); send_rx(8'hDD);
        chk("drop a_b_fun", {ALU_A, ALU_B, ALU_FUN}, {8'h11, 8'h22, 4'h3});
        chk("drop tx_data", TX_DATA, 8'h44);
        TX_READY = 1'b1;
        recv("drop lo", 8'h44);
        recv("drop hi", 8'h33);
        chk("drop idle", BUSY, 0);
        v = '{"after_drop", 32'hDD050000, 2, 16'h0055, 8'h11, 8'h22, 4'h5, 8'h55, 8'h00};
        run_frame(v);

        // Reset mid-frame
        send_rx(8'hCC); send_rx(8'h07);
        chk("midrst busy_pre", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midrst busy", BUSY, 0);
        chk("midrst tx_valid", TX_VALID, 0);
        chk("midrst a_b_fun", {ALU_A, ALU_B, ALU_FUN}, 0);
        v = '{"after_rst", 32'hDD000000, 2, 16'h0000, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00};
        run_frame(v);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
